// File: rtl/summation_pkg.sv
// summation_pkg: shared state encoding and default widths for the summation FSMD.
`default_nettype none

package summation_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_N_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/summation_adder.sv
// summation_adder: WIDTH-bit accumulate step with carry-out.
// SUMMATION_SAT_EN defined -> result clamps to all-ones on carry; otherwise wraps.
`default_nettype none

module summation_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry    = full_sum[WIDTH];

`ifdef SUMMATION_SAT_EN
  // Once clamped, every further positive add carries again, so the value sticks.
  assign result = carry ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
  assign result = full_sum[WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/summation_fsmd.sv
// summation_fsmd: arithmetic-series sum n_first..n_last by step with start/busy/done handshake.
// Optional saturation build via SUMMATION_SAT_EN (implemented in summation_adder).
`default_nettype none

module summation_fsmd
  import summation_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int N_WIDTH = DEFAULT_N_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n_first,
  input  logic [N_WIDTH-1:0] n_last,
  input  logic [N_WIDTH-1:0] step,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               overflow
);

  state_t             state;
  logic [N_WIDTH-1:0] first_q;
  logic [N_WIDTH-1:0] last_q;
  logic [N_WIDTH-1:0] step_q;
  logic [N_WIDTH-1:0] idx;
  logic [WIDTH-1:0]   acc;
  logic               ovf;

  logic [WIDTH-1:0]   idx_ext;
  logic [WIDTH-1:0]   add_result;
  logic               add_carry;
  logic [N_WIDTH:0]   next_idx;

  assign idx_ext  = WIDTH'(idx);
  // One extra bit so an index that runs past the top of the range still ends the series.
  assign next_idx = {1'b0, idx} + {1'b0, step_q};

  summation_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a      (acc),
    .b      (idx_ext),
    .result (add_result),
    .carry  (add_carry)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      first_q  <= '0;
      last_q   <= '0;
      step_q   <= '0;
      idx      <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      sum      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            first_q <= n_first;
            last_q  <= n_last;
            step_q  <= (step == '0) ? N_WIDTH'(1) : step;
            busy    <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          acc <= '0;
          idx <= first_q;
          ovf <= 1'b0;
          if (first_q > last_q) begin
            sum      <= '0;
            overflow <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            state <= ACC;
          end
        end
        ACC: begin
          acc <= add_result;
          ovf <= ovf | add_carry;
          idx <= next_idx[N_WIDTH-1:0];
          if (next_idx > {1'b0, last_q}) begin
            sum      <= add_result;
            overflow <= ovf | add_carry;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
